// File: rtl/rtf6829a_mmu.sv
// Paged MMU: 2 tasks x 32 pages of 2 KB, register window at $F800+num*$80, 24-bit physical out.
// Translation and register reads are combinational; state and map updates happen on the rising edge.
module rtf6829a_mmu #(
  parameter int unsigned pInterruptWrites = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  num,
  input  logic        dma,
  input  logic        rw_n,
  input  logic [7:0]  dbi,
  output logic [7:0]  dbo,
  input  logic [15:0] adr,
  output logic [23:0] padr_o,
  output logic        wp_o
);

  logic       map_wp [2][32];
  logic [4:0] map_hi [2][32];
  logic [7:0] map_lo [2][32];

  logic        enable;
  logic        op_key;
  logic        acc_key;
  logic [7:0]  fuse;
  logic [7:0]  run;
  logic        prev_wr;
  logic [15:0] prev_adr;

  logic [15:0] base;
  logic [6:0]  off;
  logic        reg_sel;
  logic        reg_wr;
  logic        cpu_wr;
  logic        fuse_wr;
  logic        fuse_expire;
  logic        desc;
  logic [7:0]  run_next;
  logic        int_force;
  logic        unused;

  assign base    = 16'hF800 + {7'b0, num, 7'b0};
  assign off     = adr[6:0];
  assign reg_sel = !dma && (adr[15:7] == base[15:7]);
  assign reg_wr  = reg_sel && !rw_n;
  assign cpu_wr  = !dma && !rw_n;
  assign fuse_wr = reg_wr && (off == 7'h49);
  assign fuse_expire = !fuse_wr && (fuse == 8'd1);
  assign unused  = &{1'b0, dbi[6:5]};

  // Interrupt stacking shows up as back-to-back writes to descending addresses.
  always_comb begin
    desc      = cpu_wr && prev_wr && (adr == prev_adr - 16'd1);
    run_next  = desc ? run + 8'd1 : 8'd1;
    int_force = cpu_wr && (run_next == 8'(pInterruptWrites));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable   <= 1'b0;
      op_key   <= 1'b0;
      acc_key  <= 1'b0;
      fuse     <= 8'd0;
      run      <= 8'd0;
      prev_wr  <= 1'b0;
      prev_adr <= 16'd0;
    end else begin
      prev_wr <= cpu_wr;
      if (cpu_wr) prev_adr <= adr;
      if (!cpu_wr || int_force) run <= 8'd0;
      else                      run <= run_next;

      if (fuse_wr)            fuse <= dbi;
      else if (fuse != 8'd0)  fuse <= fuse - 8'd1;

      if (reg_wr && off == 7'h41) acc_key <= dbi[0];

      if (reg_wr && off == 7'h40) begin
        op_key <= dbi[0];
        enable <= 1'b1;
      end else if (int_force) begin
        op_key <= 1'b0;
      end else if (fuse_expire) begin
        op_key <= acc_key;
      end
    end
  end

  // Map RAM is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (reg_wr && !off[6]) begin
      if (!off[0]) begin
        map_wp[acc_key][off[5:1]] <= dbi[7];
        map_hi[acc_key][off[5:1]] <= dbi[4:0];
      end else begin
        map_lo[acc_key][off[5:1]] <= dbi;
      end
    end
  end

  always_comb begin
    dbo = 8'h00;
    if (reg_sel && rw_n) begin
      if (!off[6]) begin
        if (off[0]) dbo = map_lo[acc_key][off[5:1]];
        else        dbo = {map_wp[acc_key][off[5:1]], 2'b00, map_hi[acc_key][off[5:1]]};
      end else begin
        case (off)
          7'h40:   dbo = {7'b0, op_key};
          7'h41:   dbo = {7'b0, acc_key};
          7'h49:   dbo = fuse;
          default: dbo = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    padr_o = {8'h00, adr};
    wp_o   = 1'b0;
    if (enable && !dma) begin
      padr_o = {map_hi[op_key][adr[15:11]], map_lo[op_key][adr[15:11]], adr[10:0]};
      wp_o   = !rw_n && map_wp[op_key][adr[15:11]];
    end
  end

endmodule

// File: tb/tb_rtf6829a_mmu.sv
// Scenario bench for rtf6829a_mmu: expected values queued with stimulus, popped at the negedge.
module tb_rtf6829a_mmu;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  num;
  logic        dma;
  logic        rw_n;
  logic [7:0]  dbi;
  logic [7:0]  dbo;
  logic [15:0] adr;
  logic [23:0] padr_o;
  logic        wp_o;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] e;

  always #5 clk = ~clk;

  rtf6829a_mmu #(.pInterruptWrites(3)) dut (
    .clk(clk), .rst(rst), .num(num), .dma(dma), .rw_n(rw_n), .dbi(dbi),
    .dbo(dbo), .adr(adr), .padr_o(padr_o), .wp_o(wp_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drives a bus cycle and stops at the negedge so outputs can be sampled.
  task automatic drive(input logic d, input logic r, input logic [15:0] a, input logic [7:0] data);
    dma = d; rw_n = r; adr = a; dbi = data;
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] data);
    drive(1'b0, 1'b0, a, data);
    finish_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; num = 2'd0;
    drive(1'b0, 1'b1, 16'h1234, 8'h00);
    finish_cycle();
    drive(1'b0, 1'b0, 16'h1234, 8'h55);
    checks++;
    if (padr_o !== 24'h001234 || dbo !== 8'h00 || wp_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: padr=%h dbo=%h wp=%b expected 001234 00 0", padr_o, dbo, wp_o);
    end
    finish_cycle();
    rst = 1'b0;
    begin
      logic [15:0] a [4] = '{16'hF840, 16'hF841, 16'hF849, 16'h1234};
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(i == 3 ? 24'h001234 : 24'h000000);
        drive(1'b0, 1'b1, a[i], 8'h00);
        e = exp_q.pop_front();
        checks++;
        if (i < 3 && dbo !== e[7:0]) begin
          errors++;
          $display("FAIL reset_reg[%0d]: dbo=%h expected %h", i, dbo, e[7:0]);
        end
        if (i == 3 && padr_o !== e) begin
          errors++;
          $display("FAIL reset_passthru: padr=%h expected %h", padr_o, e);
        end
        finish_cycle();
      end
    end
  endtask

  task automatic test_program_map();
    for (int p = 0; p < 32; p++) begin
      wr(16'hF800 + 16'(2 * p), (p >= 24) ? 8'h1F : 8'h00);
      wr(16'hF801 + 16'(2 * p), 8'(p));
    end
    wr(16'hF841, 8'h01);
    wr(16'hF804, 8'h85);
    wr(16'hF805, 8'hAB);
    begin
      logic [15:0] a [6]  = '{16'hF804, 16'hF805, 16'hF841, 16'hF840, 16'hF8C1, 16'hF841};
      logic [7:0]  ev [6] = '{8'h85, 8'hAB, 8'h01, 8'h00, 8'h01, 8'h00};
      logic [1:0]  n [6]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
      for (int i = 0; i < 6; i++) begin
        num = n[i];
        exp_q.push_back({16'h0, ev[i]});
        drive(1'b0, 1'b1, a[i], 8'h00);
        e = exp_q.pop_front();
        checks++;
        if (dbo !== e[7:0]) begin
          errors++;
          $display("FAIL map_readback[%0d]: dbo=%h expected %h", i, dbo, e[7:0]);
        end
        finish_cycle();
      end
    end
    num = 2'd0;
    drive(1'b1, 1'b0, 16'hF841, 8'h00);
    finish_cycle();
    exp_q.push_back(24'h01);
    drive(1'b0, 1'b1, 16'hF841, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (dbo !== e[7:0]) begin
      errors++;
      $display("FAIL dma_reg_write_ignored: dbo=%h expected %h", dbo, e[7:0]);
    end
    finish_cycle();
    wr(16'hF841, 8'h00);
    begin
      logic [15:0] a [3]  = '{16'hF83C, 16'hF83D, 16'hF805};
      logic [7:0]  ev [3] = '{8'h1F, 8'h1E, 8'h02};
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back({16'h0, ev[i]});
        drive(1'b0, 1'b1, a[i], 8'h00);
        e = exp_q.pop_front();
        checks++;
        if (dbo !== e[7:0]) begin
          errors++;
          $display("FAIL task0_readback[%0d]: dbo=%h expected %h", i, dbo, e[7:0]);
        end
        finish_cycle();
      end
    end
  endtask

  task automatic test_translate();
    wr(16'hF840, 8'h00);
    begin
      logic [15:0] a [6]  = '{16'h1000, 16'hF000, 16'h07FF, 16'hFFFF, 16'hC000, 16'h1000};
      logic        r [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [23:0] ev [6] = '{24'h001000, 24'hF8F000, 24'h0007FF, 24'hF8FFFF, 24'hF8C000, 24'h001000};
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back(ev[i]);
        drive(1'b0, r[i], a[i], 8'h00);
        e = exp_q.pop_front();
        checks++;
        if (padr_o !== e || wp_o !== 1'b0) begin
          errors++;
          $display("FAIL translate[%0d]: padr=%h wp=%b expected %h 0", i, padr_o, wp_o, e);
        end
        finish_cycle();
      end
    end
  endtask

  task automatic test_wp_dma();
    wr(16'hF840, 8'h01);
    begin
      logic        d [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic        r [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] a [4]  = '{16'h1000, 16'h1000, 16'h1000, 16'h17FF};
      logic [23:0] ep [4] = '{24'h2D5800, 24'h2D5800, 24'h001000, 24'h2D5FFF};
      logic        ew [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({ew[i], ep[i][22:0]});
        drive(d[i], r[i], a[i], 8'h00);
        e = exp_q.pop_front();
        checks++;
        if (padr_o[22:0] !== e[22:0] || padr_o[23] !== ep[i][23] || wp_o !== e[23]) begin
          errors++;
          $display("FAIL wp_dma[%0d]: padr=%h wp=%b expected %h %b", i, padr_o, wp_o, ep[i], ew[i]);
        end
        finish_cycle();
      end
    end
  endtask

  task automatic test_interrupt();
    wr(16'h00FD, 8'h11);
    wr(16'h00FC, 8'h22);
    exp_q.push_back(24'h01);
    drive(1'b0, 1'b1, 16'hF840, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (dbo !== e[7:0]) begin
      errors++;
      $display("FAIL intr_two_writes: dbo=%h expected %h", dbo, e[7:0]);
    end
    finish_cycle();
    wr(16'h00FD, 8'h11);
    wr(16'h00FC, 8'h22);
    wr(16'h00FB, 8'h33);
    exp_q.push_back(24'h00);
    drive(1'b0, 1'b1, 16'hF840, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (dbo !== e[7:0]) begin
      errors++;
      $display("FAIL intr_force: dbo=%h expected %h", dbo, e[7:0]);
    end
    finish_cycle();
  endtask

  task automatic test_fuse();
    wr(16'hF841, 8'h01);
    wr(16'hF849, 8'h04);
    begin
      logic [15:0] a [6]  = '{16'hF849, 16'hF840, 16'hF849, 16'hF840, 16'hF840, 16'hF849};
      logic [7:0]  ev [6] = '{8'h04, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00};
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back({16'h0, ev[i]});
        drive(1'b0, 1'b1, a[i], 8'h00);
        e = exp_q.pop_front();
        checks++;
        if (dbo !== e[7:0]) begin
          errors++;
          $display("FAIL fuse[%0d]: dbo=%h expected %h", i, dbo, e[7:0]);
        end
        finish_cycle();
      end
    end
  endtask

  task automatic test_fuse_abort();
    wr(16'hF849, 8'h03);
    drive(1'b0, 1'b1, 16'h0000, 8'h00);
    finish_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0000, 8'h00);
    finish_cycle();
    rst = 1'b0;
    wr(16'hF841, 8'h01);
    begin
      logic [15:0] a [6]  = '{16'hF840, 16'hF840, 16'hF840, 16'hF840, 16'hF849, 16'h1000};
      logic [23:0] ev [6] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h001000};
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back(ev[i]);
        drive(1'b0, 1'b1, a[i], 8'h00);
        e = exp_q.pop_front();
        checks++;
        if ((i < 5 && dbo !== e[7:0]) || (i == 5 && padr_o !== e)) begin
          errors++;
          $display("FAIL fuse_abort[%0d]: dbo=%h padr=%h expected %h", i, dbo, padr_o, e);
        end
        finish_cycle();
      end
    end
  endtask

  task automatic test_priority();
    wr(16'hF840, 8'h00);
    wr(16'hF849, 8'h01);
    wr(16'hF840, 8'h00);
    exp_q.push_back(24'h00);
    drive(1'b0, 1'b1, 16'hF840, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (dbo !== e[7:0]) begin
      errors++;
      $display("FAIL prio_reg_over_fuse: dbo=%h expected %h", dbo, e[7:0]);
    end
    finish_cycle();
    wr(16'hF849, 8'h03);
    wr(16'h00FD, 8'h00);
    wr(16'h00FC, 8'h00);
    wr(16'h00FB, 8'h00);
    exp_q.push_back(24'h00);
    drive(1'b0, 1'b1, 16'hF840, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (dbo !== e[7:0]) begin
      errors++;
      $display("FAIL prio_intr_over_fuse: dbo=%h expected %h", dbo, e[7:0]);
    end
    finish_cycle();
    wr(16'hF842, 8'h00);
    wr(16'hF841, 8'h01);
    wr(16'hF840, 8'h01);
    exp_q.push_back(24'h01);
    drive(1'b0, 1'b1, 16'hF840, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (dbo !== e[7:0]) begin
      errors++;
      $display("FAIL prio_reg_over_intr: dbo=%h expected %h", dbo, e[7:0]);
    end
    finish_cycle();
  endtask

  initial begin
    rst = 1'b1; num = 2'd0; dma = 1'b0; rw_n = 1'b1; adr = 16'h0000; dbi = 8'h00;
    test_reset();
    test_program_map();
    test_translate();
    test_wp_dma();
    test_interrupt();
    test_fuse();
    test_fuse_abort();
    test_priority();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
